lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MREQ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Bit positions inside req_ld_type
    localparam int unsigned LD_LB  = 6;
    localparam int unsigned LD_LH  = 5;
    localparam int unsigned LD_LW  = 4;
    localparam int unsigned LD_LD  = 3;
    localparam int unsigned LD_LBU = 2;
    localparam int unsigned LD_LHU = 1;
    localparam int unsigned LD_LWU = 0;

    // Bit positions inside req_st_type
    localparam int unsigned ST_SB = 3;
    localparam int unsigned ST_SH = 2;
    localparam int unsigned ST_SW = 1;
    localparam int unsigned ST_SD = 0;

    // Access size encodings (log2 of byte count)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Unshifted byte mask for an access of the given size
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data placement and load lane extraction.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    localparam int unsigned STRB = XLEN / 8,
    localparam int unsigned OFFW = $clog2(STRB)
) (
    input  logic [OFFW-1:0] st_off,
    input  logic [1:0]      st_size,
    input  logic [XLEN-1:0] st_data,
    output logic [STRB-1:0] wmask_c,
    output logic [XLEN-1:0] wdata_c,
    input  logic [OFFW-1:0] ld_off,
    input  logic [1:0]      ld_size,
    input  logic            ld_signed,
    input  logic [XLEN-1:0] ld_word,
    output logic [XLEN-1:0] rdata_c
);

    logic [63:0] lane;
    logic [63:0] ext;

    // Store side: mask and data move up by the byte offset, wrapping past the bus width is dropped
    always_comb begin
        wmask_c = STRB'(size_mask(st_size)) << st_off;
        wdata_c = st_data << {st_off, 3'b000};
    end

    // Load side: bring the addressed lane to bit 0, then sign- or zero-extend
    always_comb begin
        lane = 64'(ld_word) >> {ld_off, 3'b000};
        ext  = lane;
        case (ld_size)
            SZ_B:    ext = {{56{ld_signed & lane[7]}},  lane[7:0]};
            SZ_H:    ext = {{48{ld_signed & lane[15]}}, lane[15:0]};
            SZ_W:    ext = {{32{ld_signed & lane[31]}}, lane[31:0]};
            default: ext = lane;
        endcase
        rdata_c = XLEN'(ext);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access between core and memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned AW   = 64,
    parameter int unsigned STRB = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [6:0]      req_ld_type,
    input  logic [3:0]      req_st_type,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [STRB-1:0] mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata
);

    localparam int unsigned OFFW    = $clog2(STRB);
    localparam bit          IS_RV32 = (XLEN == 32);

    lsu_state_e      state;
    logic [OFFW-1:0] ld_off;
    logic [1:0]      ld_size;
    logic            ld_signed;

    logic            is_ld;
    logic            is_st;
    logic            type_bad;
    logic            misaligned;
    logic            req_err;
    logic            req_signed;
    logic [1:0]      req_size;

    logic [STRB-1:0] align_wmask;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] align_rdata;

    // Request decode: size, signedness and legality of the incoming access
    always_comb begin
        req_size   = SZ_B;
        misaligned = 1'b0;
        is_ld      = |req_ld_type;
        is_st      = |req_st_type;
        type_bad   = (is_ld == is_st)
                   || (is_ld && !$onehot(req_ld_type))
                   || (is_st && !$onehot(req_st_type))
                   || (IS_RV32 && (req_ld_type[LD_LD] || req_st_type[ST_SD]));
        req_signed = req_ld_type[LD_LB] | req_ld_type[LD_LH]
                   | req_ld_type[LD_LW] | req_ld_type[LD_LD];

        if (req_ld_type[LD_LD] || req_st_type[ST_SD]) begin
            req_size = SZ_D;
        end else if (req_ld_type[LD_LW] || req_ld_type[LD_LWU] || req_st_type[ST_SW]) begin
            req_size = SZ_W;
        end else if (req_ld_type[LD_LH] || req_ld_type[LD_LHU] || req_st_type[ST_SH]) begin
            req_size = SZ_H;
        end

        case (req_size)
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = |req_addr[1:0];
            SZ_D:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase

        req_err = type_bad | misaligned;
    end

    // Lane steering for the request being accepted and the word being returned
    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_off    (req_addr[OFFW-1:0]),
        .st_size   (req_size),
        .st_data   (req_wdata),
        .wmask_c   (align_wmask),
        .wdata_c   (align_wdata),
        .ld_off    (ld_off),
        .ld_size   (ld_size),
        .ld_signed (ld_signed),
        .ld_word   (mem_resp_rdata),
        .rdata_c   (align_rdata)
    );

    // Transaction sequencer: accept, issue to memory, collect, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            ld_off        <= '0;
            ld_size       <= SZ_B;
            ld_signed     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        ld_off      <= req_addr[OFFW-1:0];
                        ld_size     <= req_size;
                        ld_signed   <= req_signed;
                        mem_req_wen <= is_st;
                        if (req_err) begin
                            // Bad requests never touch memory
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state         <= MREQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {req_addr[AW-1:OFFW], {OFFW{1'b0}}};
                            mem_req_wdata <= is_st ? align_wdata : '0;
                            mem_req_wmask <= align_wmask;
                        end
                    end
                end
                MREQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_req_wen ? '0 : align_rdata;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with an in-bench reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [6:0]  req_ld_type;
    logic [3:0]  req_st_type;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    lsu_ctrl #(.XLEN(64), .AW(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ld_type    (req_ld_type),
        .req_st_type    (req_st_type),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model expectations for the transaction in flight
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic [63:0] exp_maddr;
    logic        exp_wen;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;

    // monitor bookkeeping
    bit          mon_en = 1'b0;
    bit          mreq_pend = 1'b0;
    bit          resp_pend = 1'b0;
    int          mreq_cycles = 0;
    int          mem_hs = 0;
    int          resp_hs = 0;
    logic [63:0] cap_rdata;
    logic        cap_err;
    logic [63:0] cap_maddr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wmask;

    localparam logic [63:0] WORD = 64'h1122_3344_8566_7788;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what a single request must produce, from the access rules alone
    task automatic model(input logic [6:0] ld, input logic [3:0] st, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] word);
        int          nbytes;
        int          off;
        bit          sgn;
        bit          err;
        logic [15:0] m;
        logic [63:0] val;
        nbytes = 0;
        sgn    = 1'b0;
        err    = 1'b0;
        off    = int'(addr[2:0]);
        if ($countones(ld) + $countones(st) != 1) begin
            err = 1'b1;
        end else if (ld != 7'd0) begin
            case (ld)
                7'b1000000: begin nbytes = 1; sgn = 1'b1; end
                7'b0100000: begin nbytes = 2; sgn = 1'b1; end
                7'b0010000: begin nbytes = 4; sgn = 1'b1; end
                7'b0001000: begin nbytes = 8; sgn = 1'b1; end
                7'b0000100: nbytes = 1;
                7'b0000010: nbytes = 2;
                default:    nbytes = 4;
            endcase
        end else begin
            case (st)
                4'b1000: nbytes = 1;
                4'b0100: nbytes = 2;
                4'b0010: nbytes = 4;
                default: nbytes = 8;
            endcase
        end
        if (!err) begin
            if ((off % nbytes) != 0) err = 1'b1;
        end
        m   = ((16'd1 << nbytes) - 16'd1) << off;
        val = 64'd0;
        for (int b = 0; b < nbytes; b++) begin
            if (off + b < 8) val[8*b +: 8] = word[8*(off+b) +: 8];
        end
        if (sgn && nbytes < 8 && val[8*nbytes-1]) val = val | (~64'd0 << (8*nbytes));
        exp_err   = err;
        exp_wen   = (st != 4'd0);
        exp_maddr = addr & ~64'h7;
        exp_wmask = m[7:0];
        exp_wdata = exp_wen ? (wd << (8*off)) : 64'd0;
        exp_rdata = (err || exp_wen) ? 64'd0 : val;
    endtask

    // Per-cycle compare of every valid output against the model
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            mreq_pend = 1'b0;
            resp_pend = 1'b0;
        end else begin
            if (mreq_pend) chk("mreq_hold", 64'(mem_req_valid), 64'd1);
            if (resp_pend) chk("resp_hold", 64'(resp_valid), 64'd1);
            if (mem_req_valid) begin
                mreq_cycles++;
                chk("mem_addr", mem_req_addr, exp_maddr);
                chk("mem_wen", 64'(mem_req_wen), 64'(exp_wen));
                if (exp_wen) begin
                    chk("mem_wdata", mem_req_wdata, exp_wdata);
                    chk("mem_wmask", 64'(mem_req_wmask), 64'(exp_wmask));
                end
                if (mem_req_ready) begin
                    mem_hs++;
                    cap_maddr = mem_req_addr;
                    cap_wdata = mem_req_wdata;
                    cap_wmask = mem_req_wmask;
                end
            end
            if (resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 64'(resp_err), 64'(exp_err));
                if (resp_ready) begin
                    resp_hs++;
                    cap_rdata = resp_rdata;
                    cap_err   = resp_err;
                end
            end
            mreq_pend = mem_req_valid && !mem_req_ready;
            resp_pend = resp_valid && !resp_ready;
        end
    end

    // One full transaction; starts and ends at the beginning of a cycle with the DUT idle
    task automatic run(input logic [6:0] ld, input logic [3:0] st, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] word, input int mdly, input int rdly);
        int mh0;
        int rh0;
        int mc0;
        int n;
        bit hs;
        model(ld, st, addr, wd, word);
        mh0 = mem_hs;
        rh0 = resp_hs;
        mc0 = mreq_cycles;
        req_valid   = 1'b1;
        req_addr    = addr;
        req_wdata   = wd;
        req_ld_type = ld;
        req_st_type = st;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid   = 1'b0;
        req_ld_type = 7'd0;
        req_st_type = 4'd0;
        if (!exp_err) begin
            // completions while the request is still pending must be ignored
            if (mdly > 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = ~word;
            end
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 60) begin
                if (n == mdly) begin
                    mem_req_ready  = 1'b1;
                    mem_resp_valid = 1'b0;
                end
                @(negedge clk);
                hs = mem_req_valid && mem_req_ready;
                @(posedge clk); #1;
                n++;
            end
            mem_req_ready = 1'b0;
            chk("mreq_lat", 64'(n), 64'(mdly + 1));
            mem_resp_valid = 1'b1;
            mem_resp_rdata = word;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 60) begin
            if (n == rdly) resp_ready = 1'b1;
            @(negedge clk);
            hs = resp_valid && resp_ready;
            if (hs) chk("busy_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        resp_ready = 1'b0;
        chk("resp_lat", 64'(n), 64'(rdly + 1));
        chk("resp_count", 64'(resp_hs - rh0), 64'd1);
        chk("mem_count", 64'(mem_hs - mh0), exp_err ? 64'd0 : 64'd1);
        if (exp_err) chk("err_no_mreq", 64'(mreq_cycles - mc0), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr       = 64'd0;
        req_wdata      = 64'd0;
        req_ld_type    = 7'd0;
        req_st_type    = 4'd0;
        resp_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mreq_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mreq_wen", 64'(mem_req_wen), 64'd0);
        chk("rst_mreq_addr", mem_req_addr, 64'd0);
        chk("rst_mreq_wdata", mem_req_wdata, 64'd0);
        chk("rst_mreq_wmask", 64'(mem_req_wmask), 64'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // hand-computed anchors
        run(7'b1000000, 4'd0, 64'h8000_0003, 64'd0, WORD, 0, 0);
        chk("lb_lit", cap_rdata, 64'hFFFF_FFFF_FFFF_FF85);
        chk("lb_err_lit", 64'(cap_err), 64'd0);
        run(7'b0000001, 4'd0, 64'h8000_0004, 64'd0, WORD, 0, 0);
        chk("lwu_lit", cap_rdata, 64'h0000_0000_1122_3344);
        run(7'd0, 4'b0100, 64'h8000_0006, 64'hBEEF, WORD, 0, 0);
        chk("sh_mask_lit", 64'(cap_wmask), 64'hC0);
        chk("sh_wdata_lit", cap_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_addr_lit", cap_maddr, 64'h8000_0000);
        run(7'b0010000, 4'd0, 64'h8000_0002, 64'd0, WORD, 0, 0);
        chk("lw_mis_lit", 64'(cap_err), 64'd1);

        // further loads and stores
        run(7'b0100000, 4'd0, 64'h8000_0002, 64'd0, WORD, 0, 0);
        chk("lh_lit", cap_rdata, 64'hFFFF_FFFF_FFFF_8566);
        run(7'b0000010, 4'd0, 64'h8000_0002, 64'd0, WORD, 0, 0);
        run(7'b0010000, 4'd0, 64'h8000_0000, 64'd0, WORD, 0, 0);
        run(7'b0001000, 4'd0, 64'h8000_0008, 64'd0, WORD, 0, 0);
        run(7'b0000100, 4'd0, 64'h8000_0007, 64'd0, WORD, 0, 0);
        run(7'd0, 4'b1000, 64'h8000_0005, 64'hAB, WORD, 0, 0);
        run(7'd0, 4'b0010, 64'h8000_0004, 64'hDEAD_BEEF, WORD, 0, 0);
        run(7'd0, 4'b0001, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, WORD, 0, 0);

        // illegal and misaligned requests
        run(7'b1000000, 4'b1000, 64'h8000_0000, 64'd0, WORD, 0, 0);
        run(7'b1100000, 4'd0, 64'h8000_0000, 64'd0, WORD, 0, 0);
        run(7'd0, 4'd0, 64'h8000_0000, 64'd0, WORD, 0, 0);
        run(7'd0, 4'b0011, 64'h8000_0000, 64'd0, WORD, 0, 0);
        run(7'd0, 4'b0001, 64'h8000_0004, 64'h55, WORD, 0, 2);
        run(7'b0100000, 4'd0, 64'h8000_0001, 64'd0, WORD, 0, 0);

        // backpressure on both sides
        run(7'b0001000, 4'd0, 64'h8000_0010, 64'd0, WORD, 5, 3);
        run(7'd0, 4'b0100, 64'h8000_0002, 64'h1234, WORD, 5, 3);

        // reset while waiting on memory abandons the access
        model(7'b0001000, 4'd0, 64'h8000_0008, 64'd0, WORD);
        req_valid   = 1'b1;
        req_addr    = 64'h8000_0008;
        req_ld_type = 7'b0001000;
        @(posedge clk); #1;
        req_valid     = 1'b0;
        req_ld_type   = 7'd0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("rst_txn_mreq", 64'(mem_req_valid), 64'd1);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst           = 1'b1;
        @(posedge clk); #1;
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = WORD;
        @(negedge clk);
        chk("rst_wait_ready", 64'(req_ready), 64'd1);
        chk("rst_wait_mreq", 64'(mem_req_valid), 64'd0);
        chk("rst_wait_maddr", mem_req_addr, 64'd0);
        chk("rst_wait_resp", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_late_resp", 64'(resp_valid), 64'd0);
            chk("rst_late_ready", 64'(req_ready), 64'd1);
        end
        @(posedge clk); #1;

        // unit recovers after the abandoned access
        run(7'b0000001, 4'd0, 64'h8000_0004, 64'd0, WORD, 1, 1);
        chk("post_rst_lit", cap_rdata, 64'h0000_0000_1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
